csa_resolve_adder: RTL

//  Carry-propagate stage downstream of the Wallace-tree carry-save rows.

---
 rtl/csa_resolve_adder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/csa_resolve_adder.sv
// -----------------------------------------------------------------------------
// csa_resolve_adder
//   Carry-propagate stage behind the Wallace-tree carry-save rows. It resolves
//   the redundant pair (sum vector, carry vector) into one binary word:
//       result = sum_in + (carry_in << 1)   mod 2^WIDTH
//   The add is a chunked ripple that resolves CHUNK bits per cycle, which keeps
//   the carry chain short. Only one operation is in flight at a time. There is a
//   valid/ready handshake on both sides.
//
//   Build option:
//     CSA_RESOLVE_ONECYCLE_EN  when defined, the ADD state does the full-width
//                              add in one cycle and CHUNK is ignored. Ports and
//                              handshake are the same in both builds.
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      synchronous active-low reset
//     in_valid   in   1      upstream offers a (sum_in, carry_in) pair
//     in_ready   out  1      block can accept (IDLE only)
//     sum_in     in   WIDTH  CSA sum vector
//     carry_in   in   WIDTH  CSA carry vector, unshifted (bit i weighs 2^(i+1))
//     out_valid  out  1      result valid (DONE only)
//     out_ready  in   1      downstream takes the result
//     result     out  WIDTH  resolved sum, held while out_valid=1
//     busy       out  1      high in ADD or DONE
// -----------------------------------------------------------------------------
module csa_resolve_adder #(
    parameter int WIDTH = 66,
    parameter int CHUNK = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] carry_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] opb_s;

    // The carry vector is stored unshifted. Shifting it here drops bit WIDTH-1,
    // whose weight is 2^WIDTH and falls outside the result.
    assign opb_s = carry_r << 1;

`ifdef CSA_RESOLVE_ONECYCLE_EN
    logic [WIDTH-1:0] full_s;
    logic             last_s;

    // Single-cycle full-width resolve; the carry out of the MSB is dropped
    assign full_s = sum_r + opb_s;
    assign last_s = 1'b1;
`else
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SHW    = $clog2(NCHUNK * CHUNK);

    logic [IDXW-1:0]  idx_r;
    logic             cy_r;
    logic [SHW-1:0]   shift_s;
    logic [CHUNK-1:0] sl_a_s;
    logic [CHUNK-1:0] sl_b_s;
    logic [CHUNK:0]   add_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] ins_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;

    // Slice adder. Bits above WIDTH shift in as zeros, so the short top slice
    // needs no special case. Its carry lands outside the result mask.
    always_comb begin
        shift_s    = SHW'(idx_r) * SHW'(CHUNK);
        sl_a_s     = CHUNK'(sum_r >> shift_s);
        sl_b_s     = CHUNK'(opb_s >> shift_s);
        add_s      = {1'b0, sl_a_s} + {1'b0, sl_b_s} + {{CHUNK{1'b0}}, cy_r};
        mask_s     = WIDTH'({CHUNK{1'b1}}) << shift_s;
        ins_s      = WIDTH'(add_s[CHUNK-1:0]) << shift_s;
        res_next_s = (result_r & ~mask_s) | (ins_s & mask_s);
        last_s     = (idx_r == IDXW'(NCHUNK - 1));
    end
`endif

    // FSM next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_s = ST_ADD;
                else          state_s = ST_IDLE;
            end
            ST_ADD: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_ADD;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Operand capture and result accumulation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r    <= {WIDTH{1'b0}};
            carry_r  <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
`ifndef CSA_RESOLVE_ONECYCLE_EN
            idx_r    <= {IDXW{1'b0}};
            cy_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        sum_r   <= sum_in;
                        carry_r <= carry_in;
`ifndef CSA_RESOLVE_ONECYCLE_EN
                        idx_r   <= {IDXW{1'b0}};
                        cy_r    <= 1'b0;
`endif
                    end
                end
                ST_ADD: begin
`ifdef CSA_RESOLVE_ONECYCLE_EN
                    result_r <= full_s;
`else
                    result_r <= res_next_s;
                    cy_r     <= add_s[CHUNK];
                    idx_r    <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
`endif
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign result    = result_r;
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_ADD) || (state_r == ST_DONE);

endmodule
